iob_rom_sp_arbiter: RTL and testbench
=====================================

Name: iob_rom_sp_arbiter

Overview:
- Shares one single-port synchronous ROM (1-cycle read latency, registered output, read enable) among N_REQ requesters.
- Sits between requester ports and the ROM instance.
- Arbitrates one read per cycle (round-robin by default), drives ROM enable and address, and routes the ROM read data back to the granted requester one cycle later.
- Full throughput: back-to-back grants with no bubbles.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- ADDR_W, 4, ROM address width.
- DATA_W, 8, ROM data width.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  synchronous active-high reset.
- req_valid_i  input  N_REQ  read request per requester.
- req_addr_i  input  N_REQ*ADDR_W  packed addresses; requester k uses bits [k*ADDR_W +: ADDR_W].
- req_ready_o  output  N_REQ  one-hot grant; request k accepted when req_valid_i[k] & req_ready_o[k] at rising edge.
- rsp_valid_o  output  N_REQ  one-hot response strobe.
- rsp_data_o  output  DATA_W  read data; meaningful only while any rsp_valid_o bit is high.
- rom_r_en_o  output  1  ROM read enable.
- rom_addr_o  output  ADDR_W  ROM address.
- rom_r_data_i  input  DATA_W  ROM read data, valid the cycle after rom_r_en_o.

Behaviour:
- Single clock domain; reset is synchronous and active-high, sampled on rising clk_i.
- Reset values (registered state): rr_ptr=0, rsp_valid_o=0.
- While rst_i is high, req_ready_o=0 and rom_r_en_o=0, overriding the combinational logic below.
- Grant logic (combinational): search requesters starting at rr_ptr, upward, wrapping modulo N_REQ. The first k with req_valid_i[k]=1 gets req_ready_o[k]=1; all other bits are 0. If no requests, req_ready_o=0.
- rom_r_en_o = |req_valid_i & ~rst_i.
- rom_addr_o = address of granted requester; 0 when no grant.
- Pointer update: on a grant to k, rr_ptr <= (k+1) mod N_REQ at the clock edge. With no grant, rr_ptr holds.
  - Wrap: a grant to N_REQ-1 sets rr_ptr to 0.
  - This computation must be correct for non-power-of-2 N_REQ; no modulo by truncation.
- Response: rsp_valid_o <= req_ready_o (registered one-hot), so the strobe is high for exactly the cycle after acceptance.
- rsp_data_o = rom_r_data_i (pass-through); request latency is 1 cycle.
- No response backpressure: a requester must consume data in the strobe cycle.
- Requester may change address or drop valid freely when not granted. Requests are not latched; an ungranted request just competes again next cycle.
- Single requester asserting every cycle: granted every cycle, strobe every cycle.
- All N_REQ asserting continuously: grants cycle 0,1,..,N_REQ-1,0,...; each requester is served exactly once per N_REQ cycles; no starvation.
- Reset mid-operation: in-flight read is dropped, so rsp_valid_o is 0 in the cycle after rst_i is high, even if a grant occurred the cycle before.
  - The first grant after reset deasserts goes to the lowest-index valid requester.
- X on req_addr_i of ungranted requesters must not propagate to rom_addr_o.

Optional Feature:
- Macro: IOB_ROM_SP_ARBITER_FIXED_PRIO_EN.
- Defined: fixed priority; lowest index valid requester always wins.
  - rr_ptr register is removed; the search always starts at 0.
  - Starvation of higher indices is permitted.
- Undefined (default): round-robin behaviour as specified above.
- Latency, ports and response timing are identical in both modes.

Test Plan (N_REQ=3, ADDR_W=4, DATA_W=8, ROM preloaded rom[i]=i+32, single-port ROM model with 1-cycle latency):
- Single requester: req 1 valid, addr sweeps 0..15 one per cycle -> req_ready_o=3'b010 every cycle; rsp_valid_o=3'b010 next cycle with rsp_data_o=addr+32 (0x20..0x2F).
- All three valid continuously, addrs 1/2/3 -> grants 001,010,100,001,... after reset; responses 0x21,0x22,0x23 repeating, each 1 cycle after its grant.
- Requesters 0 and 2 valid, rr_ptr=1 after a grant to 0 -> next grant to 2, then 0, alternating; requester 1 idle receives no strobes.
- Wrap check: grant to requester 2 -> rr_ptr=0. Then only 1 and 2 valid -> grant to 1, then to 2.
- rst_i pulsed for one cycle immediately after a grant to 0 (addr 5) -> no rsp_valid_o pulse; rom_r_en_o=0 during reset. First post-reset grant goes to the lowest valid index.
- With IOB_ROM_SP_ARBITER_FIXED_PRIO_EN: all three valid continuously -> req_ready_o=3'b001 every cycle and only requester 0 receives responses.

Source files
------------

// File: rtl/iob_rom_sp_arbiter.sv
// -----------------------------------------------------------------------------
// iob_rom_sp_arbiter
//
// Shares one single-port synchronous ROM among N_REQ requesters. The ROM has a
// 1-cycle read latency, a registered output and a read enable. Each cycle the
// arbiter accepts at most one read, drives the ROM enable and address, and
// returns the ROM data one cycle later with a one-hot strobe that names the
// requester. Back-to-back grants are supported with no bubbles.
//
// Arbitration:
//   default : round-robin. The search starts at rr_ptr and moves upward,
//             wrapping at N_REQ. After a grant to k, rr_ptr becomes k+1, or 0
//             when k is N_REQ-1.
//   IOB_ROM_SP_ARBITER_FIXED_PRIO_EN defined : fixed priority. The lowest
//             valid index always wins and the rr_ptr register is removed.
//             Ports, latency and response timing are the same in both modes.
//
// Parameters:
//   N_REQ   number of requesters (2..8)
//   ADDR_W  ROM address width
//   DATA_W  ROM data width
//
// Ports:
//   clk_i         in   1             system clock
//   rst_i         in   1             synchronous active-high reset
//   req_valid_i   in   N_REQ         read request per requester
//   req_addr_i    in   N_REQ*ADDR_W  packed addresses; requester k uses
//                                    bits [k*ADDR_W +: ADDR_W]
//   req_ready_o   out  N_REQ         one-hot grant (combinational)
//   rsp_valid_o   out  N_REQ         one-hot response strobe
//   rsp_data_o    out  DATA_W        read data, meaningful while a strobe is high
//   rom_r_en_o    out  1             ROM read enable
//   rom_addr_o    out  ADDR_W        ROM address
//   rom_r_data_i  in   DATA_W        ROM read data, valid the cycle after enable
// -----------------------------------------------------------------------------
module iob_rom_sp_arbiter #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*ADDR_W-1:0] req_addr_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic [N_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]       rsp_data_o,
  output logic                    rom_r_en_o,
  output logic [ADDR_W-1:0]       rom_addr_o,
  input  logic [DATA_W-1:0]       rom_r_data_i
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Pick the first valid requester, starting at 'start' and wrapping at
  // N_REQ. The wrap subtracts N_REQ explicitly, so non-power-of-2 counts
  // never alias onto out-of-range indices.
  function automatic logic [N_REQ-1:0] rr_pick(
    input logic [N_REQ-1:0] valid,
    input logic [PTR_W-1:0] start
  );
    logic [N_REQ-1:0] pick;
    logic             found;
    int               pos;
    pick  = {N_REQ{1'b0}};
    found = 1'b0;
    for (int off = 0; off < N_REQ; off++) begin
      pos = int'(start) + off;
      if (pos >= N_REQ) begin
        pos = pos - N_REQ;
      end else begin
        pos = pos;
      end
      for (int k = 0; k < N_REQ; k++) begin
        if (!found && (k == pos) && valid[k]) begin
          pick[k] = 1'b1;
          found   = 1'b1;
        end else begin
          pick[k] = pick[k];
        end
      end
    end
    return pick;
  endfunction

  // AND-OR address mux. Ungranted lanes are forced to zero before the OR,
  // so an X on an idle requester's address cannot reach the ROM.
  function automatic logic [ADDR_W-1:0] addr_sel(
    input logic [N_REQ-1:0]        onehot,
    input logic [N_REQ*ADDR_W-1:0] addrs
  );
    logic [ADDR_W-1:0] acc;
    acc = {ADDR_W{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      acc = acc | ({ADDR_W{onehot[k]}} & addrs[k*ADDR_W +: ADDR_W]);
    end
    return acc;
  endfunction

  logic [N_REQ-1:0] grant_s;
  logic [PTR_W-1:0] start_s;
  logic [N_REQ-1:0] rsp_valid_r;

`ifdef IOB_ROM_SP_ARBITER_FIXED_PRIO_EN

  // Fixed priority: the search always begins at requester 0.
  assign start_s = {PTR_W{1'b0}};

`else

  logic [PTR_W-1:0] rr_ptr_r;
  logic [PTR_W-1:0] next_ptr_s;

  // Pointer value after a grant: one past the winner, wrapping to 0 after
  // the last requester.
  function automatic logic [PTR_W-1:0] ptr_after(input logic [N_REQ-1:0] onehot);
    logic [PTR_W-1:0] nxt;
    nxt = {PTR_W{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      if (onehot[k]) begin
        if (k == N_REQ - 1) begin
          nxt = {PTR_W{1'b0}};
        end else begin
          nxt = PTR_W'(k + 1);
        end
      end else begin
        nxt = nxt;
      end
    end
    return nxt;
  endfunction

  assign start_s = rr_ptr_r;

  // Next round-robin pointer derived from the current grant.
  always_comb begin
    next_ptr_s = rr_ptr_r;
    if (|grant_s) begin
      next_ptr_s = ptr_after(grant_s);
    end else begin
      next_ptr_s = rr_ptr_r;
    end
  end

  // Round-robin pointer register; holds when nothing is granted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_r <= {PTR_W{1'b0}};
    end else begin
      rr_ptr_r <= next_ptr_s;
    end
  end

`endif

  // Grant selection; reset suppresses every grant.
  always_comb begin
    grant_s = {N_REQ{1'b0}};
    if (rst_i) begin
      grant_s = {N_REQ{1'b0}};
    end else begin
      grant_s = rr_pick(req_valid_i, start_s);
    end
  end

  // Response strobe: the grant delayed by one cycle, matching the ROM latency.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_r <= {N_REQ{1'b0}};
    end else begin
      rsp_valid_r <= grant_s;
    end
  end

  assign req_ready_o = grant_s;
  assign rom_r_en_o  = (|req_valid_i) & ~rst_i;
  assign rom_addr_o  = addr_sel(grant_s, req_addr_i);
  // Masking with reset drops a read that is still in flight when reset
  // arrives, so no stale strobe leaks out during the reset cycle.
  assign rsp_valid_o = rsp_valid_r & {N_REQ{~rst_i}};
  assign rsp_data_o  = rom_r_data_i;

endmodule

// File: tb/tb_iob_rom_sp_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for iob_rom_sp_arbiter (N_REQ=3, ADDR_W=4, DATA_W=8).
// The ROM model returns rom[i] = i + 32 one cycle after the read enable.
// Each cycle, the bench predicts the grant and pushes the expected response
// into a queue. The response is popped and compared one cycle later.
// -----------------------------------------------------------------------------
module tb_iob_rom_sp_arbiter;

  localparam int N  = 3;
  localparam int AW = 4;
  localparam int DW = 8;

  logic            clk;
  logic            rst;
  logic [N-1:0]    valid;
  logic [N*AW-1:0] addr;
  logic [N-1:0]    ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            rom_en;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_q;

  typedef struct {
    logic [N-1:0]  vld;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_ptr    = 0;

  iob_rom_sp_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (valid),
    .req_addr_i   (addr),
    .req_ready_o  (ready),
    .rsp_valid_o  (rsp_valid),
    .rsp_data_o   (rsp_data),
    .rom_r_en_o   (rom_en),
    .rom_addr_o   (rom_addr),
    .rom_r_data_i (rom_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port ROM, contents rom[i] = i + 32, registered output.
  always @(posedge clk) begin
    if (rom_en) rom_q <= 8'(rom_addr) + 8'd32;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference arbitration: the first valid index at or after the pointer.
  function automatic logic [N-1:0] model_grant(input logic [N-1:0] v);
    logic [N-1:0] one;
    int s;
    int k;
    one = 3'b001;
    s   = m_ptr;
`ifdef IOB_ROM_SP_ARBITER_FIXED_PRIO_EN
    s = 0;
`endif
    for (int off = 0; off < N; off++) begin
      k = (s + off) % N;
      if (v[k]) return one << k;
    end
    return '0;
  endfunction

  // One clock cycle: drive inputs, check last cycle's response, check grant.
  task automatic step(input logic r, input logic [N-1:0] v,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [AW-1:0] a2, output logic [N-1:0] got);
    rsp_t          e;
    rsp_t          nx;
    logic [N-1:0]  exp_v;
    logic [N-1:0]  g;
    logic [AW-1:0] ga;
    @(negedge clk);
    rst   = r;
    valid = v;
    addr  = {a2, a1, a0};
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_empty: got 0 entries expected 1");
    end else begin
      e     = sb.pop_front();
      exp_v = r ? '0 : e.vld;
      check("rsp_valid", rsp_valid, exp_v);
      if (exp_v != '0) check("rsp_data", rsp_data, e.data);
    end
    g  = r ? '0 : model_grant(v);
    ga = '0;
    for (int k = 0; k < N; k++) if (g[k]) ga = addr[k*AW +: AW];
    check("req_ready", ready, g);
    check("rom_r_en", rom_en, (r ? 1'b0 : |v));
    check("rom_addr", rom_addr, ga);
    nx.vld  = g;
    nx.data = 8'(ga) + 8'd32;
    sb.push_back(nx);
    if (r) m_ptr = 0;
    else for (int k = 0; k < N; k++) if (g[k]) m_ptr = (k + 1) % N;
    got = ready;
  endtask

  initial begin
    logic [N-1:0] got;
    logic [N-1:0] exp_g;
    rsp_t         first;
    rst   = 1'b1;
    valid = '0;
    addr  = '0;
    first.vld  = '0;
    first.data = '0;
    sb.push_back(first);

    // Reset state: no grant, no enable, no strobe while reset is held.
    step(1'b1, 3'b111, 4'd1, 4'd2, 4'd3, got);
    step(1'b1, 3'b111, 4'd1, 4'd2, 4'd3, got);

    // Single requester 1 sweeping the whole address space.
    for (int a = 0; a < 16; a++) begin
      step(1'b0, 3'b010, 4'd0, 4'(a), 4'd0, got);
      check("single_grant", got, 3'b010);
    end

    // All three requesters continuously after reset: grants 001,010,100,...
    step(1'b1, 3'b000, 4'd0, 4'd0, 4'd0, got);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 3'b111, 4'd1, 4'd2, 4'd3, got);
      exp_g = 3'b001;
      exp_g = exp_g << (i % 3);
      check("rr_all_grant", got, exp_g);
    end

    // Grant to 0 moves the pointer to 1. Requesters 0 and 2 then alternate.
    step(1'b0, 3'b001, 4'd4, 4'd0, 4'd6, got);
    check("pair_first", got, 3'b001);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 3'b101, 4'd4, 4'd0, 4'd6, got);
      exp_g = (i % 2 == 0) ? 3'b100 : 3'b001;
      check("pair_alt", got, exp_g);
    end

    // Wrap: a grant to 2 sets the pointer to 0, so 1 wins before 2.
    step(1'b0, 3'b100, 4'd0, 4'd0, 4'd9, got);
    check("wrap_g2", got, 3'b100);
    step(1'b0, 3'b110, 4'd0, 4'd7, 4'd8, got);
    check("wrap_g1", got, 3'b010);
    step(1'b0, 3'b110, 4'd0, 4'd7, 4'd8, got);
    check("wrap_g2b", got, 3'b100);

    // Reset right after a grant to 0 drops the read, and the pointer restarts.
    step(1'b0, 3'b001, 4'd5, 4'd0, 4'd0, got);
    check("pre_rst_grant", got, 3'b001);
    step(1'b1, 3'b111, 4'd5, 4'd6, 4'd7, got);
    step(1'b0, 3'b111, 4'd5, 4'd6, 4'd7, got);
    check("post_rst_grant", got, 3'b001);

    // X on ungranted addresses must not reach the ROM address.
    step(1'b0, 3'b001, 4'd6, 4'bxxxx, 4'bxxxx, got);
    check("x_iso_grant", got, 3'b001);

    // Idle cycles: no grant, enable low, address zero; the last response drains.
    step(1'b0, 3'b000, 4'd0, 4'd0, 4'd0, got);
    step(1'b0, 3'b000, 4'd0, 4'd0, 4'd0, got);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
